vga_dmem_reader: RTL

VGA-side client of the processor's second data-memory port. Once per frame it burst-reads the snake state words from dmem into a 320-bit snapshot for the renderer, and writes the player's direction word back into dmem for the game program to poll. It drives the `address_dmem_fromVGA`, `data_fromVGA` and `wren_fromVGA` inputs of the processor wrapper and consumes `q_dmem_toVGA`.

---
 rtl/vga_dmem_reader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vga_dmem_reader.sv
// vga_dmem_reader
//   VGA-side client of the processor's second data-memory port. Once per frame
//   it burst-reads the snake state words into a 320-bit snapshot for the
//   renderer. It also writes the player's direction word back to dmem so the
//   game program can poll it.
//
// Ports
//   clock                 in   1   system clock (dmem runs on ~clock)
//   reset                 in   1   synchronous, active-high
//   frame_start           in   1   one-cycle pulse at vertical blank
//   dir_wr_req            in   1   request to write dir_wr_data
//   dir_wr_data           in  32   direction word
//   address_dmem_fromVGA  out 12   dmem address
//   data_fromVGA          out 32   dmem write data
//   wren_fromVGA          out  1   dmem write enable
//   q_dmem_toVGA          in  32   dmem read data
//   snake_data            out 320  snapshot, word i at [32i+31:32i]
//   snapshot_done         out  1   one-cycle pulse when snake_data updates
//   busy                  out  1   high whenever the FSM is not idle
module vga_dmem_reader #(
  parameter logic [11:0] BASE_ADDR = 12'd100,
  parameter int          NUM_WORDS = 10,
  parameter logic [11:0] DIR_ADDR  = 12'd99
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_start,
  input  logic         dir_wr_req,
  input  logic [31:0]  dir_wr_data,
  output logic [11:0]  address_dmem_fromVGA,
  output logic [31:0]  data_fromVGA,
  output logic         wren_fromVGA,
  input  logic [31:0]  q_dmem_toVGA,
  output logic [319:0] snake_data,
  output logic         snapshot_done,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int         MAX_WORDS = 10;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_WORDS - 1);

  logic [1:0]   state_q,      state_d;
  logic [3:0]   idx_q,        idx_d;
  logic         frame_pend_q, frame_pend_d;
  logic         wr_pend_q,    wr_pend_d;
  logic [31:0]  wr_buf_q,     wr_buf_d;
  logic [31:0]  shadow_q [MAX_WORDS];
  logic [31:0]  shadow_d [MAX_WORDS];
  logic [11:0]  addr_q,       addr_d;
  logic [31:0]  data_q,       data_d;
  logic         wren_q,       wren_d;
  logic [319:0] snake_q,      snake_d;
  logic         done_q,       done_d;
  logic         busy_q,       busy_d;
  logic         scan_entry;

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that the registered bus reflects the current state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    snake_d    = snake_q;
    addr_d     = 12'd0;
    data_d     = 32'd0;
    wren_d     = 1'b0;
    done_d     = 1'b0;
    scan_entry = 1'b0;

    // Newest request always wins the buffer.
    if (dir_wr_req) begin
      wr_buf_d = dir_wr_data;
    end else begin
      wr_buf_d = wr_buf_q;
    end

    case (state_q)
      S_IDLE: begin
        // Requests arriving at this very edge count as pending so that
        // the write or scan starts in the next cycle.
        if (wr_pend_q || dir_wr_req) begin
          state_d = S_WRITE;
          addr_d  = DIR_ADDR;
          data_d  = wr_buf_d;
          wren_d  = 1'b1;
        end else if (frame_pend_q || frame_start) begin
          state_d    = S_SCAN;
          idx_d      = 4'd0;
          addr_d     = BASE_ADDR;
          scan_entry = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_SCAN: begin
        // dmem read completed on the falling edge of this cycle.
        shadow_d[idx_q] = q_dmem_toVGA;
        if (idx_q == LAST_IDX) begin
          state_d = S_COMMIT;
          idx_d   = 4'd0;
        end else begin
          idx_d  = idx_q + 4'd1;
          addr_d = BASE_ADDR + {8'd0, idx_d};
        end
      end
      S_COMMIT: begin
        // Whole-frame copy; unused upper words always read zero.
        for (int i = 0; i < MAX_WORDS; i++) begin
          if (i < NUM_WORDS) begin
            snake_d[32*i +: 32] = shadow_q[i];
          end else begin
            snake_d[32*i +: 32] = 32'd0;
          end
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A frame_start coinciding with scan entry is absorbed by that scan.
    frame_pend_d = (frame_pend_q | frame_start) & ~scan_entry;
    // A request at the edge that ends WRITE keeps the flag for another write.
    wr_pend_d    = dir_wr_req | (wr_pend_q & (state_q != S_WRITE));
    busy_d       = (state_d != S_IDLE);
  end

  // State, pending flags, shadow buffer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      frame_pend_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_buf_q     <= 32'd0;
      for (int i = 0; i < MAX_WORDS; i++) begin
        shadow_q[i] <= 32'd0;
      end
      addr_q       <= 12'd0;
      data_q       <= 32'd0;
      wren_q       <= 1'b0;
      snake_q      <= 320'd0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_pend_q <= frame_pend_d;
      wr_pend_q    <= wr_pend_d;
      wr_buf_q     <= wr_buf_d;
      for (int i = 0; i < MAX_WORDS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      snake_q      <= snake_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign address_dmem_fromVGA = addr_q;
  assign data_fromVGA         = data_q;
  assign wren_fromVGA         = wren_q;
  assign snake_data           = snake_q;
  assign snapshot_done        = done_q;
  assign busy                 = busy_q;

endmodule
